// File: rtl/alkcin_if.sv
// Signal bundle between the ALK carry-input control and the alkcin carry-return block.
// Optional ALKCIN_STICKY_EN adds the sticky-carry report and its clear.
interface alkcin_if #(
  parameter int CNT_W = 6
);
  logic             step_en_h;
  logic             alu_cout_l;
  logic             alkc_ld_h;
  logic             alkc_clr_h;
  logic             div_start_h;
  logic             div_abort_h;
  logic             alkc_flag_h;
  logic             carry_invert_h;
  logic             quo_bit_h;
  logic             div_busy_h;
  logic             div_done_h;
  logic [CNT_W-1:0] div_count_h;
  logic [1:0]       dbg_state;
`ifdef ALKCIN_STICKY_EN
  logic             sticky_clr_h;
  logic             sticky_c_h;
`endif

  // Handshake: there is no valid/ready pair; every input is qualified only by
  // step_en_h on a rising clk_h edge, and every output is a registered level.
  modport master (
    output step_en_h, alu_cout_l, alkc_ld_h, alkc_clr_h, div_start_h, div_abort_h,
`ifdef ALKCIN_STICKY_EN
    output sticky_clr_h,
    input  sticky_c_h,
`endif
    input  alkc_flag_h, carry_invert_h, quo_bit_h, div_busy_h, div_done_h,
    input  div_count_h, dbg_state
  );

  modport slave (
    input  step_en_h, alu_cout_l, alkc_ld_h, alkc_clr_h, div_start_h, div_abort_h,
`ifdef ALKCIN_STICKY_EN
    input  sticky_clr_h,
    output sticky_c_h,
`endif
    output alkc_flag_h, carry_invert_h, quo_bit_h, div_busy_h, div_done_h,
    output div_count_h, dbg_state
  );
endinterface

// File: rtl/alkcin.sv
// ALK carry-return path: ALKC carry flag plus the non-restoring DIVDBL step sequencer.
// Define ALKCIN_STICKY_EN to add the sticky carry-seen flag (sticky_c_h / sticky_clr_h).
module alkcin #(
  parameter int DIV_STEPS = 32,
  parameter int CNT_W     = 6
) (
  input  logic     clk_h,
  input  logic     reset_l,
  alkcin_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic             alkc;
  logic             carry_inv;
  logic             quo;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic             alu_carry;

  assign alu_carry = ~bus.alu_cout_l;

  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      state     <= IDLE;
      alkc      <= 1'b0;
      carry_inv <= 1'b0;
      quo       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
    end else if (bus.step_en_h) begin
      if (bus.alkc_clr_h)      alkc <= 1'b0;
      else if (state == DIV)   alkc <= alu_carry;
      else if (bus.alkc_ld_h)  alkc <= alu_carry;

      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.div_start_h && !bus.div_abort_h) begin
            state     <= DIV;
            busy      <= 1'b1;
            count     <= CNT_W'(DIV_STEPS - 1);
            carry_inv <= 1'b1;   // first non-restoring step always subtracts
          end else begin
            carry_inv <= 1'b0;
          end
        end
        DIV: begin
          if (bus.div_abort_h) begin
            state     <= IDLE;
            busy      <= 1'b0;
            count     <= '0;
            carry_inv <= 1'b0;
          end else begin
            quo <= alu_carry;
            if (count == '0) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              carry_inv <= 1'b0;
            end else begin
              count     <= count - 1'b1;
              // carry out means the partial remainder stayed nonnegative
              carry_inv <= alu_carry;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          count     <= '0;
          carry_inv <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          count     <= '0;
          carry_inv <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALKCIN_STICKY_EN
  logic sticky;

  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      sticky <= 1'b0;
    end else if (bus.step_en_h) begin
      if (bus.sticky_clr_h)                      sticky <= 1'b0;
      else if (bus.alkc_ld_h || (state == DIV))  sticky <= sticky | alu_carry;
    end
  end

  assign bus.sticky_c_h = sticky;
`endif

  assign bus.alkc_flag_h    = alkc;
  assign bus.carry_invert_h = carry_inv;
  assign bus.quo_bit_h      = quo;
  assign bus.div_busy_h     = busy;
  assign bus.div_done_h     = done;
  assign bus.div_count_h    = count;
  assign bus.dbg_state      = state;

endmodule

// File: tb/tb_alkcin.sv
// Self-checking bench for alkcin: directed scenarios plus randomized traffic against a
// step-level reference model of the divide sequence and ALKC flag.
module tb_alkcin;
  localparam int DIV_STEPS = 32;
  localparam int CNT_W     = 6;
`ifdef ALKCIN_STICKY_EN
  localparam int OUT_W = CNT_W + 6;
`else
  localparam int OUT_W = CNT_W + 5;
`endif

  logic clk_h;
  logic reset_l;
  int   n_tests = 0;
  int   n_fail  = 0;

  alkcin_if #(.CNT_W(CNT_W)) bus ();

  alkcin #(.DIV_STEPS(DIV_STEPS), .CNT_W(CNT_W)) dut (
    .clk_h   (clk_h),
    .reset_l (reset_l),
    .bus     (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_h = 1'b0;
    forever #5 clk_h = ~clk_h;
  end

  // ---------------- reference model ----------------
  bit m_alkc, m_quo, m_last_c, m_in_div, m_in_done, m_sticky;
  int m_taken;   // divide steps already performed in the current sequence
  logic [OUT_W-1:0] exp_q[$];

  task automatic model_reset();
    m_alkc = 0; m_quo = 0; m_last_c = 0; m_in_div = 0; m_in_done = 0; m_sticky = 0;
    m_taken = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit en, input bit carry, input bit ld, input bit clr,
                            input bit start, input bit abort, input bit sclr);
    if (!en) return;
    if (sclr)                  m_sticky = 0;
    else if (ld || m_in_div)   m_sticky = m_sticky | carry;
    if (clr)                   m_alkc = 0;
    else if (m_in_div || ld)   m_alkc = carry;
    if (m_in_div) begin
      if (abort) m_in_div = 0;
      else begin
        m_quo    = carry;
        m_last_c = carry;
        m_taken++;
        if (m_taken == DIV_STEPS) begin
          m_in_div  = 0;
          m_in_done = 1;
        end
      end
    end else if (m_in_done) begin
      m_in_done = 0;
    end else if (start && !abort) begin
      m_in_div = 1;
      m_taken  = 0;
    end
  endtask

  function automatic int model_count();
    return m_in_div ? (DIV_STEPS - 1 - m_taken) : 0;
  endfunction

  function automatic logic [OUT_W-1:0] model_vec();
    logic             ci;
    logic [CNT_W-1:0] cnt;
    ci  = m_in_div ? ((m_taken == 0) ? 1'b1 : m_last_c) : 1'b0;
    cnt = CNT_W'(model_count());
`ifdef ALKCIN_STICKY_EN
    return {m_sticky, m_alkc, ci, m_quo, m_in_div, m_in_done, cnt};
`else
    return {m_alkc, ci, m_quo, m_in_div, m_in_done, cnt};
`endif
  endfunction

  function automatic logic [OUT_W-1:0] dut_vec();
`ifdef ALKCIN_STICKY_EN
    return {bus.sticky_c_h, bus.alkc_flag_h, bus.carry_invert_h, bus.quo_bit_h,
            bus.div_busy_h, bus.div_done_h, bus.div_count_h};
`else
    return {bus.alkc_flag_h, bus.carry_invert_h, bus.quo_bit_h,
            bus.div_busy_h, bus.div_done_h, bus.div_count_h};
`endif
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit en, input bit cout_l, input bit ld, input bit clr,
                       input bit start, input bit abort, input bit sclr);
    bus.step_en_h   = en;
    bus.alu_cout_l  = cout_l;
    bus.alkc_ld_h   = ld;
    bus.alkc_clr_h  = clr;
    bus.div_start_h = start;
    bus.div_abort_h = abort;
`ifdef ALKCIN_STICKY_EN
    bus.sticky_clr_h = sclr;
`endif
    model_step(en, ~cout_l, ld, clr, start, abort, sclr);
    exp_q.push_back(model_vec());
    @(posedge clk_h);
    #1;
    check("cycle", 32'(dut_vec()), 32'(exp_q.pop_front()));
  endtask

  task automatic idle_cycle();
    cycle(1, 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0);
  endtask

  task automatic apply_reset();
    reset_l = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_h);
    #3 reset_l = 1'b1;
    #1;
  endtask

  // Runs enabled divide steps with random carries until the model count reaches target.
  task automatic run_to_count(input int target);
    for (int i = 0; i < 2 * DIV_STEPS && model_count() != target; i++)
      cycle(1, 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0);
    check("reach_count", 32'(model_count()), 32'(target));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.step_en_h = 0; bus.alu_cout_l = 1; bus.alkc_ld_h = 0; bus.alkc_clr_h = 0;
    bus.div_start_h = 0; bus.div_abort_h = 0;
`ifdef ALKCIN_STICKY_EN
    bus.sticky_clr_h = 0;
`endif
    apply_reset();
    check("reset_outs", 32'(dut_vec()), 32'd0);
    check("reset_state", 32'(bus.dbg_state), 32'd0);

    // ALKC load then clear-beats-load
    cycle(1, 0, 1, 0, 0, 0, 0);
    check("alkc_ld", 32'(bus.alkc_flag_h), 32'd1);
    cycle(1, 0, 1, 1, 0, 0, 0);
    check("alkc_clr_wins", 32'(bus.alkc_flag_h), 32'd0);

    // full divide, carries 1,0,1,0...
    begin
      bit last_carry;
      cycle(1, 1, 0, 0, 1, 0, 0);
      check("start_ci", 32'(bus.carry_invert_h), 32'd1);
      check("start_cnt", 32'(bus.div_count_h), 32'(DIV_STEPS - 1));
      for (int e = 2; e <= DIV_STEPS + 2; e++) begin
        bit c;
        c = (e <= DIV_STEPS + 1) ? ((e - 1) % 2 == 1) : 1'b0;
        if (e <= DIV_STEPS + 1) last_carry = c;
        cycle(1, ~c, 0, 0, 0, 0, 0);
        check("div_done_edge", 32'(bus.div_done_h), 32'(e == DIV_STEPS + 1));
        if (e <= DIV_STEPS)
          check("ci_tracks", 32'(bus.carry_invert_h), 32'(c));
      end
      check("final_quo", 32'(bus.quo_bit_h), 32'(last_carry));
      check("idle_after", 32'(bus.dbg_state), 32'd0);
    end

    // stall at count 10: everything holds, abort ignored
    begin
      bit hold_alkc, hold_quo;
      cycle(1, 1, 0, 0, 1, 0, 0);
      run_to_count(10);
      hold_alkc = m_alkc;
      hold_quo  = m_quo;
      for (int i = 0; i < 5; i++) begin
        cycle(0, 1'(i), 1, i[0], 1, ~i[0], 0);
        check("stall_cnt", 32'(bus.div_count_h), 32'd10);
        check("stall_alkc", 32'(bus.alkc_flag_h), 32'(hold_alkc));
        check("stall_quo", 32'(bus.quo_bit_h), 32'(hold_quo));
        check("stall_busy", 32'(bus.div_busy_h), 32'd1);
      end
      run_to_count(4);
      // abort together with start at count 4
      cycle(1, 0, 0, 0, 1, 1, 0);
      check("abort_cnt", 32'(bus.div_count_h), 32'd0);
      check("abort_ci", 32'(bus.carry_invert_h), 32'd0);
      check("abort_state", 32'(bus.dbg_state), 32'd0);
      for (int i = 0; i < 6; i++) begin
        idle_cycle();
        check("abort_no_done", 32'(bus.div_done_h), 32'd0);
      end
    end

    // asynchronous reset mid-divide at count 17
    cycle(1, 1, 0, 0, 1, 0, 0);
    run_to_count(17);
    #2 reset_l = 1'b0;
    #1;
    check("async_rst_outs", 32'(dut_vec()), 32'd0);
    check("async_rst_state", 32'(bus.dbg_state), 32'd0);
    model_reset();
    @(posedge clk_h);
    #3 reset_l = 1'b1;
    #1;
    idle_cycle();

`ifdef ALKCIN_STICKY_EN
    cycle(1, 1, 1, 0, 0, 0, 0);
    check("sticky_c0", 32'(bus.sticky_c_h), 32'd0);
    cycle(1, 0, 1, 0, 0, 0, 0);
    check("sticky_c1", 32'(bus.sticky_c_h), 32'd1);
    cycle(1, 1, 1, 0, 0, 0, 0);
    check("sticky_hold", 32'(bus.sticky_c_h), 32'd1);
    cycle(1, 0, 1, 0, 0, 0, 1);
    check("sticky_clr", 32'(bus.sticky_c_h), 32'd0);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 9) != 0),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
